// File: rtl/jt89_decim.sv
// Boxcar decimator for the jt89 PSG stereo mix: averages DECIM input samples
// and presents mean*32 as signed 16-bit stereo through a one-entry valid/ready register.
module jt89_decim #(
  parameter int DECIM = 64,
  parameter int LOG2D = $clog2(DECIM),
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic signed [10:0]      inL,
  input  logic signed [10:0]      inR,
  input  logic                    flush,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic signed [OUT_W-1:0] sampleL,
  output logic signed [OUT_W-1:0] sampleR,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam int ACC_W = 11 + LOG2D;
  // Dropping the low LOG2D-5 bits of the window sum is floor(mean*32).
  localparam int SH    = LOG2D - 5;

  logic signed [ACC_W-1:0] acc_l_r, acc_r_r;
  logic signed [ACC_W-1:0] acc_l_nx_s, acc_r_nx_s;
  logic signed [ACC_W-1:0] sum_l_s, sum_r_s;
  logic [LOG2D-1:0]        cnt_r, cnt_nx_s;
  logic signed [OUT_W-1:0] sample_l_r, sample_r_r;
  logic signed [OUT_W-1:0] sample_l_nx_s, sample_r_nx_s;
  logic                    valid_r, valid_nx_s;
  logic                    overrun_r, overrun_nx_s;
  logic                    last_s, result_s, xfer_s, ovr_set_s;

  assign sum_l_s  = acc_l_r + {{LOG2D{inL[10]}}, inL};
  assign sum_r_s  = acc_r_r + {{LOG2D{inR[10]}}, inR};
  assign last_s   = clk_en & (&cnt_r);
  assign result_s = last_s & ~flush;
  assign xfer_s   = valid_r & sample_ready;
  assign ovr_set_s = result_s & valid_r & ~sample_ready;

  // Accumulator and window counter next state; flush overrides everything.
  always_comb begin
    acc_l_nx_s = acc_l_r;
    acc_r_nx_s = acc_r_r;
    cnt_nx_s   = cnt_r;
    if (flush || last_s) begin
      acc_l_nx_s = {ACC_W{1'b0}};
      acc_r_nx_s = {ACC_W{1'b0}};
      cnt_nx_s   = {LOG2D{1'b0}};
    end else if (clk_en) begin
      acc_l_nx_s = sum_l_s;
      acc_r_nx_s = sum_r_s;
      cnt_nx_s   = cnt_r + {{(LOG2D-1){1'b0}}, 1'b1};
    end else begin
      cnt_nx_s   = cnt_r;
    end
  end

  // Holding register: a new result always loads, overwriting an unaccepted one.
  always_comb begin
    sample_l_nx_s = sample_l_r;
    sample_r_nx_s = sample_r_r;
    valid_nx_s    = valid_r;
    overrun_nx_s  = overrun_r;
    if (result_s) begin
      sample_l_nx_s = sum_l_s[ACC_W-1:SH];
      sample_r_nx_s = sum_r_s[ACC_W-1:SH];
      valid_nx_s    = 1'b1;
    end else if (xfer_s) begin
      valid_nx_s    = 1'b0;
    end else begin
      valid_nx_s    = valid_r;
    end
    if (ovr_set_s) begin
      overrun_nx_s = 1'b1;
    end else if (clr_overrun) begin
      overrun_nx_s = 1'b0;
    end else begin
      overrun_nx_s = overrun_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l_r    <= {ACC_W{1'b0}};
      acc_r_r    <= {ACC_W{1'b0}};
      cnt_r      <= {LOG2D{1'b0}};
      sample_l_r <= {OUT_W{1'b0}};
      sample_r_r <= {OUT_W{1'b0}};
      valid_r    <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      acc_l_r    <= acc_l_nx_s;
      acc_r_r    <= acc_r_nx_s;
      cnt_r      <= cnt_nx_s;
      sample_l_r <= sample_l_nx_s;
      sample_r_r <= sample_r_nx_s;
      valid_r    <= valid_nx_s;
      overrun_r  <= overrun_nx_s;
    end
  end

  assign sample_valid = valid_r;
  assign sampleL      = sample_l_r;
  assign sampleR      = sample_r_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_jt89_decim.sv
// Directed + random bench for jt89_decim against a window-list reference model.
module tb_jt89_decim;
  localparam int DECIM = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic signed [10:0] inL = 11'sd0;
  logic signed [10:0] inR = 11'sd0;
  logic flush = 1'b0;
  logic sample_ready = 1'b0;
  logic clr_overrun = 1'b0;
  logic sample_valid, overrun;
  logic signed [15:0] sampleL, sampleR;

  int n_assert = 0;
  int n_fail = 0;

  // reference model state
  int win_l[$];
  int win_r[$];
  logic        m_valid = 1'b0;
  logic        m_ovr = 1'b0;
  logic [15:0] m_l = 16'h0000;
  logic [15:0] m_r = 16'h0000;

  jt89_decim #(.DECIM(DECIM)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .inL(inL), .inR(inR),
    .flush(flush), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sampleL(sampleL), .sampleR(sampleR), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic logic [15:0] window_out(input int q[$]);
    int s = 0;
    foreach (q[k]) s += q[k];
    return 16'(fdiv(s * 32, DECIM));
  endfunction

  task automatic model_reset();
    win_l.delete(); win_r.delete();
    m_valid = 1'b0; m_ovr = 1'b0; m_l = 16'h0000; m_r = 16'h0000;
  endtask

  task automatic model_tick();
    logic res = 1'b0;
    logic set_ovr;
    logic [15:0] nl = 16'h0000, nr = 16'h0000;
    if (!rst_n) return;
    if (flush) begin
      win_l.delete(); win_r.delete();
    end else if (clk_en) begin
      win_l.push_back(int'(inL)); win_r.push_back(int'(inR));
      if (win_l.size() == DECIM) begin
        res = 1'b1; nl = window_out(win_l); nr = window_out(win_r);
        win_l.delete(); win_r.delete();
      end
    end
    set_ovr = res && m_valid && !sample_ready;
    if (res) begin
      m_valid = 1'b1; m_l = nl; m_r = nr;
    end else if (m_valid && sample_ready) m_valid = 1'b0;
    if (set_ovr) m_ovr = 1'b1;
    else if (clr_overrun) m_ovr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, {15'd0, sample_valid}, {15'd0, m_valid});
    chk({tag, ".L"}, sampleL, m_l);
    chk({tag, ".R"}, sampleR, m_r);
    chk({tag, ".ovr"}, {15'd0, overrun}, {15'd0, m_ovr});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_tick();
    #1;
    chk_model(tag);
  endtask

  task automatic run_const(input string tag, input int n_en, input int l, input int r, input int period);
    for (int i = 0; i < n_en * period; i++) begin
      clk_en = ((i % period) == period - 1);
      inL = 11'(l); inR = 11'(r);
      cycle(tag);
    end
    clk_en = 1'b0;
  endtask

  task automatic do_flush(input string tag);
    flush = 1'b1; cycle(tag); flush = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    // reset
    #2; #1;
    chk_model("reset");
    chk("reset.L", sampleL, 16'h0000);
    repeat (3) cycle("reset");
    #2 rst_n = 1'b1;

    // constant 100/-100, clk_en every 4th clk
    sample_ready = 1'b1;
    run_const("const", 64, 100, -100, 4);
    chk("const.L", sampleL, 16'sd3200);
    chk("const.R", sampleR, -16'sd3200);
    run_const("const2", 128, 100, -100, 4);

    // full scale
    run_const("full", 64, 1023, -1024, 1);
    chk("full.L", sampleL, 16'sd32736);
    chk("full.R", sampleR, -16'sd32768);

    // alternating +1/-2 : floor toward minus infinity
    do_flush("alt");
    for (int i = 0; i < DECIM; i++) begin
      clk_en = 1'b1;
      inL = (i % 2 == 0) ? 11'sd1 : -11'sd2;
      inR = (i % 2 == 0) ? -11'sd1 : 11'sd2;
      cycle("alt");
    end
    clk_en = 1'b0;
    chk("alt.L", sampleL, -16'sd16);
    chk("alt.R", sampleR, 16'sd16);
    cycle("alt");

    // overwrite while not ready, then clear overrun
    sample_ready = 1'b0;
    do_flush("ovr");
    run_const("ovr", 64, 10, 0, 1);
    chk("ovr.first", sampleL, 16'sd320);
    chk("ovr.noflag", {15'd0, overrun}, 16'd0);
    run_const("ovr", 64, 20, 0, 1);
    chk("ovr.second", sampleL, 16'sd640);
    chk("ovr.flag", {15'd0, overrun}, 16'd1);
    clr_overrun = 1'b1; cycle("clr"); clr_overrun = 1'b0;
    chk("clr.ovr", {15'd0, overrun}, 16'd0);
    chk("clr.valid", {15'd0, sample_valid}, 16'd1);
    sample_ready = 1'b1;
    cycle("drain");

    // flush mid-window
    do_flush("flush");
    run_const("flush", 30, 50, 50, 1);
    flush = 1'b1; clk_en = 1'b1; cycle("flush"); flush = 1'b0;
    run_const("flush", 63, 0, 0, 1);
    chk("flush.novalid", {15'd0, sample_valid}, 16'd0);
    run_const("flush", 1, 0, 0, 1);
    chk("flush.valid", {15'd0, sample_valid}, 16'd1);
    chk("flush.L", sampleL, 16'sd0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rdy_pct = ((i / 500) % 2 == 1) ? 3 : 80;
      clk_en = ($urandom_range(0, 2) != 0);
      inL = 11'($urandom_range(0, 2047));
      inR = 11'($urandom_range(0, 2047));
      sample_ready = ($urandom_range(0, 99) < rdy_pct);
      flush = ($urandom_range(0, 299) == 0);
      clr_overrun = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end
    flush = 1'b0; clr_overrun = 1'b0;

    // asynchronous reset mid-window with a held sample and overrun set
    sample_ready = 1'b0;
    do_flush("arst");
    run_const("arst", 64, 7, -7, 1);
    run_const("arst", 64, 7, -7, 1);
    run_const("arst", 20, 7, -7, 1);
    chk("arst.pre", {15'd0, sample_valid}, 16'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_model("arst.now");
    chk("arst.ovr", {15'd0, overrun}, 16'd0);
    #3 rst_n = 1'b1;
    sample_ready = 1'b1;
    run_const("arst.post", 63, 5, -5, 1);
    chk("arst.wait", {15'd0, sample_valid}, 16'd0);
    run_const("arst.post", 1, 5, -5, 1);
    chk("arst.L", sampleL, 16'sd160);
    chk("arst.R", sampleR, -16'sd160);
    cycle("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/jt89_decim.md
Name: jt89_decim

Overview:
Downstream stage of the jt89 PSG core. It consumes the per-clk_en signed 11-bit soundL/soundR mixer outputs, boxcar-averages them over DECIM input samples, and emits scaled signed 16-bit stereo samples at the audio rate. Samples are delivered through a single-entry valid/ready holding register to the platform audio FIFO or I2S serializer.

Parameters:
DECIM, 64, input samples per output sample; power of two, 32..1024 inclusive.
LOG2D, $clog2(DECIM), derived; not overridden by instantiator.
OUT_W, 16, output sample width; fixed at 16, the only supported value.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  input-sample strobe; same enable that drives the PSG core
inL  in  11  signed left PSG sample (soundL)
inR  in  11  signed right PSG sample (soundR)
flush  in  1  synchronous restart of the current accumulation window
sample_valid  out  1  holding register contains an undelivered sample
sample_ready  in  1  consumer accepts the sample this cycle when valid
sampleL  out  16  signed averaged left sample
sampleR  out  16  signed averaged right sample
overrun  out  1  sticky flag; a sample was overwritten before acceptance
clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n low, asynchronous): accumulators, window counter, sampleL/R, sample_valid and overrun all go to 0. All outputs are 0 during reset and remain so until the first window completes.
- Accumulators accL/accR are signed, 11+LOG2D bits wide. Inputs are sign-extended before addition. Overflow is impossible by construction.
- Window counter cnt runs 0..DECIM-1 and advances only on clk_en. With clk_en low, nothing in the accumulate path changes.
- On clk_en with cnt != DECIM-1: acc <= acc + in, and cnt increments.
- On clk_en with cnt == DECIM-1:
  - sum = acc + in.
  - acc <= 0 and cnt <= 0.
  - Result out = sum >>> (LOG2D-5), an arithmetic shift right with truncation toward minus infinity. This equals mean*32.
  - Output range is -32768..32736. No saturation is needed.
- Latency: sampleL/R and sample_valid update on the clk edge that samples the final clk_en of the window, so they are visible one cycle after that edge.
- Handshake:
  - A transfer occurs in any cycle where sample_valid and sample_ready are both high.
  - After a transfer with no new result in the same cycle, sample_valid <= 0.
  - sample_ready is ignored while sample_valid is low.
  - sampleL/R hold their value until a new result loads. They are not cleared on transfer.
- New result while holding register is empty, or while a transfer occurs in the same cycle: load the result and set sample_valid <= 1. overrun is unchanged.
- New result while sample_valid=1 and sample_ready=0: overwrite sampleL/R with the new result, keep sample_valid=1, and set overrun <= 1.
- overrun is sticky until clr_overrun is asserted. If clr_overrun and a new overrun event occur in the same cycle, the set wins.
- flush=1: acc <= 0 and cnt <= 0 regardless of clk_en, and the partial window is discarded.
  - If flush coincides with window completion, flush wins and no result is produced.
  - flush does not affect the holding register, sample_valid or overrun.
- Left and right channels share cnt and are always produced together.

Test Plan:
- Reset then constant inL=100, inR=-100, clk_en every 4th clk, DECIM=64, sample_ready=1 -> first sample_valid pulse one clk after the 64th clk_en; sampleL=3200, sampleR=-3200; pulses repeat every 256 clk.
- Full-scale inputs inL=1023, inR=-1024 -> sampleL=32736, sampleR=-32768; no wrap.
- Alternating inL=+1/-2 each clk_en, DECIM=64 -> sum=-32 and sampleL=-16 (shift 1); confirms arithmetic truncation.
- sample_ready=0 across two completed windows (inL=10, then 20) -> sampleL=640 then 320... corrected: 320 then 640, sample_valid stays 1, overrun=1; then clr_overrun pulse -> overrun=0 and sample_valid still 1.
- flush asserted at cnt=30 with inL=50 before and inL=0 after -> next sample is sampleL=0, produced 64 clk_en after the flush, not at the original boundary.
- rst_n dropped mid-window with sample_valid=1 -> sample_valid, sampleL/R and overrun go to 0 immediately (no clk edge needed); after release, the first result appears after a full DECIM clk_en.
